// File: rtl/rd_burst_ctrl_if.sv
// Request/strobe bundle between the N_CH requesters, the burst controller and the memory.
// The master side drives go/len/ws; the slave (controller) side drives the strobes and status.
interface rd_burst_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int LEN_W = 4
);
    logic [N_CH-1:0]       go;
    logic [N_CH*LEN_W-1:0] len;
    logic                  ws;
    logic                  rd;
    logic                  ds;
    logic                  err;
    logic [N_CH-1:0]       grant;
    logic [LEN_W-1:0]      beat_cnt;
    logic                  busy;

    modport master (
        output go, len, ws,
        input  rd, ds, err, grant, beat_cnt, busy
    );

    modport slave (
        input  go, len, ws,
        output rd, ds, err, grant, beat_cnt, busy
    );
endinterface

// File: rtl/rd_burst_ctrl.sv
// Round-robin multi-channel read-burst controller with wait-state stretching and timeout abort.
// All outputs are registered (Moore); go/len/ws only influence the next state.
module rd_burst_ctrl #(
    parameter int N_CH    = 4,
    parameter int LEN_W   = 4,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    rd_burst_ctrl_if.slave  bus
);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DLY, S_DONE, S_ABORT} state_t;

    state_t            r_state;
    logic [N_CH-1:0]   r_grant;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic [TO_W-1:0]   r_wait;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_rd;
    logic              r_ds;
    logic              r_err;
    logic              r_busy;

    logic              w_found;
    logic [PTR_W-1:0]  w_win_idx;
    logic [LEN_W-1:0]  w_win_len;
    int                w_idx;

    // Search upward starting just after the last winner so every channel gets a turn.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_idx     = 0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_CH) w_idx = w_idx - N_CH;
            if (!w_found && bus.go[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = PTR_W'(w_idx);
            end
        end
        w_win_len = bus.len[int'(w_win_idx)*LEN_W +: LEN_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_ptr   <= PTR_W'(N_CH - 1);
            r_rd    <= 1'b0;
            r_ds    <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_READ;
                        r_grant <= {{(N_CH-1){1'b0}}, 1'b1} << w_win_idx;
                        r_len   <= w_win_len;
                        r_ptr   <= w_win_idx;
                        r_beat  <= '0;
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_DLY;
                    r_wait  <= '0;
                end
                S_DLY: begin
                    // ws has priority: a beat that completes on the timeout cycle is not aborted.
                    if (bus.ws) begin
                        if (TIMEOUT != 0 && r_wait == TO_LAST) begin
                            r_state <= S_ABORT;
                            r_rd    <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_wait  <= r_wait + 1'b1;
                        end
                    end else if (r_beat < r_len) begin
                        r_beat  <= r_beat + 1'b1;
                        r_state <= S_READ;
                    end else begin
                        r_state <= S_DONE;
                        r_rd    <= 1'b0;
                        r_ds    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ds    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd    <= 1'b0;
                    r_ds    <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.rd       = r_rd;
    assign bus.ds       = r_ds;
    assign bus.err      = r_err;
    assign bus.grant    = r_grant;
    assign bus.beat_cnt = r_beat;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Directed bench for rd_burst_ctrl (N_CH=4, LEN_W=4, TIMEOUT=16).
// Status is packed as {rd, ds, err, busy, grant[3:0], beat_cnt[3:0]}.
module tb_rd_burst_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rd_burst_ctrl_if #(.N_CH(4), .LEN_W(4)) bus ();

    rd_burst_ctrl #(.N_CH(4), .LEN_W(4), .TO_W(8), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [11:0] st;
    assign st = {bus.rd, bus.ds, bus.err, bus.busy, bus.grant, bus.beat_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] st_exp(input logic r, input logic d, input logic e,
                                           input logic b, input logic [3:0] g,
                                           input logic [3:0] bc);
        return {r, d, e, b, g, bc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (st !== 12'h000) begin bad++; $display("FAIL reset_async got=%b want=%b", st, 12'h000); end
        tick();
        tick();
        total++;
        if (st !== 12'h000) begin bad++; $display("FAIL reset_held got=%b want=%b", st, 12'h000); end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        bus.len = '0;
        bus.go  = 4'b0001;
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0001,0)) begin bad++; $display("FAIL single_read got=%b want=%b", st, st_exp(1,0,0,1,4'b0001,0)); end
        bus.go = 4'b0000;
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0001,0)) begin bad++; $display("FAIL single_dly got=%b want=%b", st, st_exp(1,0,0,1,4'b0001,0)); end
        tick();
        total++;
        if (st !== st_exp(0,1,0,1,4'b0001,0)) begin bad++; $display("FAIL single_done got=%b want=%b", st, st_exp(0,1,0,1,4'b0001,0)); end
        tick();
        total++;
        if (st !== st_exp(0,0,0,0,4'b0000,0)) begin bad++; $display("FAIL single_idle got=%b want=%b", st, st_exp(0,0,0,0,4'b0000,0)); end
    endtask

    task automatic test_wait_burst();
        logic [3:0] eb;
        logic [11:0] e;
        bus.len[11:8] = 4'd2;
        bus.go = 4'b0100;
        tick();
        bus.go = 4'b0000;
        for (int c = 1; c <= 10; c++) begin
            bus.ws = (c >= 4 && c <= 6);
            eb = (c <= 2) ? 4'd0 : (c <= 7) ? 4'd1 : 4'd2;
            e = st_exp(c <= 9, c == 10, 0, 1, 4'b0100, eb);
            total++;
            if (st !== e) begin bad++; $display("FAIL wait_burst_c%0d got=%b want=%b", c, st, e); end
            tick();
        end
        bus.ws = 1'b0;
        total++;
        if (st !== st_exp(0,0,0,0,4'b0000,2)) begin bad++; $display("FAIL wait_burst_idle got=%b want=%b", st, st_exp(0,0,0,0,4'b0000,2)); end
        bus.len = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.len = '0;
        bus.go  = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            g = 4'b0001 << (t % 4);
            tick();
            total++;
            if (st !== st_exp(1,0,0,1,g,0)) begin bad++; $display("FAIL rr_grant_%0d got=%b want=%b", t, st, st_exp(1,0,0,1,g,0)); end
            tick();
            tick();
            total++;
            if (st !== st_exp(0,1,0,1,g,0)) begin bad++; $display("FAIL rr_done_%0d got=%b want=%b", t, st, st_exp(0,1,0,1,g,0)); end
            tick();
            total++;
            if (st !== 12'h000) begin bad++; $display("FAIL rr_idle_%0d got=%b want=%b", t, st, 12'h000); end
        end
        bus.go = 4'b0000;
    endtask

    task automatic test_timeout();
        bus.go = 4'b0010;
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0010,0)) begin bad++; $display("FAIL to_read got=%b want=%b", st, st_exp(1,0,0,1,4'b0010,0)); end
        bus.go = 4'b0000;
        bus.ws = 1'b1;
        for (int d = 1; d <= 16; d++) begin
            tick();
            total++;
            if (st !== st_exp(1,0,0,1,4'b0010,0)) begin bad++; $display("FAIL to_dly_%0d got=%b want=%b", d, st, st_exp(1,0,0,1,4'b0010,0)); end
        end
        tick();
        total++;
        if (st !== st_exp(0,0,1,1,4'b0010,0)) begin bad++; $display("FAIL to_abort got=%b want=%b", st, st_exp(0,0,1,1,4'b0010,0)); end
        bus.ws = 1'b0;
        tick();
        total++;
        if (st !== 12'h000) begin bad++; $display("FAIL to_idle got=%b want=%b", st, 12'h000); end
        // ws drops on the would-be timeout cycle: normal completion expected
        bus.go = 4'b0100;
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0100,0)) begin bad++; $display("FAIL to_next_grant got=%b want=%b", st, st_exp(1,0,0,1,4'b0100,0)); end
        bus.go = 4'b0000;
        bus.ws = 1'b1;
        for (int d = 1; d <= 16; d++) begin
            tick();
            if (d == 16) bus.ws = 1'b0;
            total++;
            if (st !== st_exp(1,0,0,1,4'b0100,0)) begin bad++; $display("FAIL to_edge_dly_%0d got=%b want=%b", d, st, st_exp(1,0,0,1,4'b0100,0)); end
        end
        tick();
        total++;
        if (st !== st_exp(0,1,0,1,4'b0100,0)) begin bad++; $display("FAIL to_edge_done got=%b want=%b", st, st_exp(0,1,0,1,4'b0100,0)); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.len[3:0] = 4'd3;
        bus.go = 4'b0001;
        tick();
        bus.go = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0001,2)) begin bad++; $display("FAIL ar_beat2 got=%b want=%b", st, st_exp(1,0,0,1,4'b0001,2)); end
        #3 rst = 1'b1;
        #1;
        total++;
        if (st !== 12'h000) begin bad++; $display("FAIL ar_immediate got=%b want=%b", st, 12'h000); end
        tick();
        total++;
        if (st !== 12'h000) begin bad++; $display("FAIL ar_held got=%b want=%b", st, 12'h000); end
        rst = 1'b0;
        bus.go = 4'b0010;
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0010,0)) begin bad++; $display("FAIL ar_regrant got=%b want=%b", st, st_exp(1,0,0,1,4'b0010,0)); end
        bus.go = 4'b0000;
        tick();
        tick();
        total++;
        if (st !== st_exp(0,1,0,1,4'b0010,0)) begin bad++; $display("FAIL ar_done got=%b want=%b", st, st_exp(0,1,0,1,4'b0010,0)); end
        tick();
    endtask

    task automatic test_late_go();
        bus.len[3:0] = 4'd1;
        bus.go = 4'b0001;
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0001,0)) begin bad++; $display("FAIL late_read0 got=%b want=%b", st, st_exp(1,0,0,1,4'b0001,0)); end
        bus.go = 4'b0000;
        bus.len[3:0] = 4'd0;
        tick();
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0001,1)) begin bad++; $display("FAIL late_read1 got=%b want=%b", st, st_exp(1,0,0,1,4'b0001,1)); end
        bus.len[3:0] = 4'd3;
        tick();
        tick();
        total++;
        if (st !== st_exp(0,1,0,1,4'b0001,1)) begin bad++; $display("FAIL late_done got=%b want=%b", st, st_exp(0,1,0,1,4'b0001,1)); end
        bus.go = 4'b0010;
        tick();
        total++;
        if (st !== st_exp(0,0,0,0,4'b0000,1)) begin bad++; $display("FAIL late_idle got=%b want=%b", st, st_exp(0,0,0,0,4'b0000,1)); end
        tick();
        total++;
        if (st !== st_exp(1,0,0,1,4'b0010,0)) begin bad++; $display("FAIL late_grant got=%b want=%b", st, st_exp(1,0,0,1,4'b0010,0)); end
        bus.go = 4'b0000;
        tick();
        tick();
        tick();
        total++;
        if (st !== st_exp(0,0,0,0,4'b0000,0)) begin bad++; $display("FAIL late_final got=%b want=%b", st, st_exp(0,0,0,0,4'b0000,0)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        bus.go  = '0;
        bus.len = '0;
        bus.ws  = 1'b0;
        test_reset();
        test_single_beat();
        test_wait_burst();
        test_round_robin();
        test_timeout();
        test_async_reset();
        test_late_go();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
